// File: rtl/merged_fifo_reader_if.sv
// Handshake bundle between the merged FIFO read port, the drain engine and the log-writer stream.
// The slave modport is the drain engine's view; master is the surrounding FIFO/sink side.
interface merged_fifo_reader_if #(
    parameter int WIDTH     = 1000,
    parameter int OUT_WIDTH = 512
);
    logic [WIDTH-1:0]     fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [31:0]          entries_done;

    modport master (
        output fifo_dout, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last, entries_done
    );
    modport slave (
        input  fifo_dout, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last, entries_done
    );
endinterface

// File: rtl/merged_fifo_reader.sv
// Drains WIDTH-bit entries from the merged log FIFO as NBEATS-beat valid/ready bursts with a last marker.
// Define MERGED_FIFO_READER_PREFETCH_EN to add a second entry register that removes the per-entry bubble.
module merged_fifo_reader #(
    parameter int WIDTH     = 1000,
    parameter int OUT_WIDTH = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    merged_fifo_reader_if.slave bus
);
    localparam int NBEATS = (WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int BIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(NBEATS - 1);

    logic [WIDTH-1:0]             r_entry;
    logic [BIW-1:0]               r_beat_idx;
    logic [31:0]                  r_entries_done;
    logic                         r_valid;
    logic                         r_armed;
    logic [NBEATS*OUT_WIDTH-1:0]  w_padded;
    logic                         w_xfer;
    logic                         w_fin;
    logic                         w_rd_en;

    assign w_xfer = r_valid && bus.out_ready;
    assign w_fin  = w_xfer && (r_beat_idx == LAST_IDX);

    always_comb begin
        w_padded            = '0;
        w_padded[WIDTH-1:0] = r_entry;
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_last     = r_valid && (r_beat_idx == LAST_IDX);
    assign bus.out_data     = r_valid ? w_padded[int'(r_beat_idx)*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign bus.entries_done = r_entries_done;
    assign bus.fifo_rd_en   = w_rd_en;

    // Pops are held off for the first cycle after reset so rd_en is low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_armed <= 1'b0;
        else        r_armed <= 1'b1;
    end

`ifdef MERGED_FIFO_READER_PREFETCH_EN
    logic [WIDTH-1:0] r_pf;
    logic             r_pf_vld;
    logic             r_pend;
    logic [1:0]       w_occ;

    // Slots held after this edge: current + prefetch + in-flight read, minus the entry finishing now.
    assign w_occ   = {1'b0, r_valid} + {1'b0, r_pf_vld} + {1'b0, r_pend} - {1'b0, w_fin};
    assign w_rd_en = r_armed && !bus.fifo_empty && (w_occ <= 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry        <= '0;
            r_pf           <= '0;
            r_pf_vld       <= 1'b0;
            r_pend         <= 1'b0;
            r_valid        <= 1'b0;
            r_beat_idx     <= '0;
            r_entries_done <= '0;
        end else begin
            r_pend <= w_rd_en;
            if (w_xfer) begin
                if (w_fin) begin
                    r_beat_idx     <= '0;
                    r_entries_done <= r_entries_done + 32'd1;
                end else begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                end
            end
            if (!r_valid || w_fin) begin
                if (r_pf_vld) begin
                    r_entry  <= r_pf;
                    r_valid  <= 1'b1;
                    r_pf_vld <= r_pend;
                    if (r_pend) r_pf <= bus.fifo_dout;
                end else if (r_pend) begin
                    r_entry <= bus.fifo_dout;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (r_pend) begin
                r_pf     <= bus.fifo_dout;
                r_pf_vld <= 1'b1;
            end
        end
    end
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;
    state_t r_state;

    assign w_rd_en = r_armed && !bus.fifo_empty && ((r_state == S_IDLE) || w_fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_entry        <= '0;
            r_valid        <= 1'b0;
            r_beat_idx     <= '0;
            r_entries_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rd_en) r_state <= S_FETCH;
                S_FETCH: begin
                    r_entry    <= bus.fifo_dout;
                    r_beat_idx <= '0;
                    r_valid    <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: if (w_xfer) begin
                    if (w_fin) begin
                        r_entries_done <= r_entries_done + 32'd1;
                        r_beat_idx     <= '0;
                        r_valid        <= 1'b0;
                        r_state        <= w_rd_en ? S_FETCH : S_IDLE;
                    end else begin
                        r_beat_idx <= r_beat_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif
endmodule
